// File: rtl/cla_sum_checker.sv
// Streaming checker for the carry-lookahead adder: compares each (a, b, s) triple
// against (a + b) mod 2^NBIT, counts vectors and errors, and latches the first failure.
module cla_sum_checker #(
    parameter int unsigned NBIT  = 7,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBIT-1:0]  a,
    input  logic [NBIT-1:0]  b,
    input  logic [NBIT-1:0]  s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [NBIT-1:0]  first_err_a,
    output logic [NBIT-1:0]  first_err_b,
    output logic [NBIT-1:0]  first_err_s,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_vec_q, num_vec_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic [NBIT-1:0]  cmp_a_q, cmp_a_d;
    logic [NBIT-1:0]  cmp_b_q, cmp_b_d;
    logic [NBIT-1:0]  cmp_s_q, cmp_s_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             fe_valid_q, fe_valid_d;
    logic [NBIT-1:0]  fe_a_q, fe_a_d;
    logic [NBIT-1:0]  fe_b_q, fe_b_d;
    logic [NBIT-1:0]  fe_s_q, fe_s_d;
    logic [CNT_W-1:0] fe_idx_q, fe_idx_d;

    logic             accept;
    logic [NBIT-1:0]  golden;

    // Carry-out is dropped on purpose: overflow wraps modulo 2^NBIT.
    assign golden = cmp_a_q + cmp_b_q;
    assign accept = (state_q == StRun) && in_valid;

    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        acc_cnt_d   = acc_cnt_q;
        cmp_valid_d = accept;
        cmp_a_d     = cmp_a_q;
        cmp_b_d     = cmp_b_q;
        cmp_s_d     = cmp_s_q;
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_cnt_q;
        fe_valid_d  = fe_valid_q;
        fe_a_d      = fe_a_q;
        fe_b_d      = fe_b_q;
        fe_s_d      = fe_s_q;
        fe_idx_d    = fe_idx_q;

        if (accept) begin
            cmp_a_d = a;
            cmp_b_d = b;
            cmp_s_d = s;
        end

        // vec_cnt_q is the 0-based index of the vector retiring this cycle.
        if (cmp_valid_q) begin
            vec_cnt_d = vec_cnt_q + CNT_W'(1);
            if (cmp_s_q != golden) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (!fe_valid_q) begin
                    fe_valid_d = 1'b1;
                    fe_a_d     = cmp_a_q;
                    fe_b_d     = cmp_b_q;
                    fe_s_d     = cmp_s_q;
                    fe_idx_d   = vec_cnt_q;
                end
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_vec_d  = num_vec;
                    acc_cnt_d  = '0;
                    vec_cnt_d  = '0;
                    err_cnt_d  = '0;
                    fe_valid_d = 1'b0;
                    fe_a_d     = '0;
                    fe_b_d     = '0;
                    fe_s_d     = '0;
                    fe_idx_d   = '0;
                    state_d    = (num_vec != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_d == num_vec_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            num_vec_q   <= '0;
            acc_cnt_q   <= '0;
            cmp_valid_q <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            cmp_s_q     <= '0;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            fe_valid_q  <= 1'b0;
            fe_a_q      <= '0;
            fe_b_q      <= '0;
            fe_s_q      <= '0;
            fe_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            acc_cnt_q   <= acc_cnt_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            cmp_s_q     <= cmp_s_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            fe_valid_q  <= fe_valid_d;
            fe_a_q      <= fe_a_d;
            fe_b_q      <= fe_b_d;
            fe_s_q      <= fe_s_d;
            fe_idx_q    <= fe_idx_d;
        end
    end

    assign in_ready        = (state_q == StRun);
    assign busy            = (state_q == StRun) || (state_q == StDrain);
    assign done            = (state_q == StDone);
    assign pass            = done && (err_cnt_q == '0);
    assign vec_cnt         = vec_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_a     = fe_a_q;
    assign first_err_b     = fe_b_q;
    assign first_err_s     = fe_s_q;
    assign first_err_idx   = fe_idx_q;

endmodule

// File: tb/tb_cla_sum_checker.sv
// Randomized self-checking bench for cla_sum_checker; expected results come from a
// plain modular-arithmetic model of each run.
module tb_cla_sum_checker;

    localparam int NB = 7;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NB-1:0] a = '0, b = '0, s = '0;
    logic          busy, done, pass;
    logic [CW-1:0] vec_cnt, err_cnt;
    logic          fe_valid;
    logic [NB-1:0] fe_a, fe_b, fe_s;
    logic [CW-1:0] fe_idx;

    logic          d4_start = 1'b0;
    logic [CW-1:0] d4_num = '0;
    logic          d4_valid = 1'b0;
    logic          d4_ready;
    logic [3:0]    d4_a = '0, d4_b = '0, d4_s = '0;
    logic          d4_busy, d4_done, d4_pass;
    logic [CW-1:0] d4_vec_cnt, d4_err_cnt;
    logic          d4_fe_valid;
    logic [3:0]    d4_fe_a, d4_fe_b, d4_fe_s;
    logic [CW-1:0] d4_fe_idx;

    int errors = 0;
    int checks = 0;

    logic [NB-1:0] tv_a [64];
    logic [NB-1:0] tv_b [64];
    logic [NB-1:0] tv_s [64];
    bit            tv_v [128];

    always #5 clk = ~clk;

    cla_sum_checker #(.NBIT(NB), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .s(s),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .first_err_valid(fe_valid), .first_err_a(fe_a), .first_err_b(fe_b),
        .first_err_s(fe_s), .first_err_idx(fe_idx)
    );

    cla_sum_checker #(.NBIT(4), .CNT_W(CW)) u_dut4 (
        .clk(clk), .rst(rst), .start(d4_start), .num_vec(d4_num),
        .in_valid(d4_valid), .in_ready(d4_ready), .a(d4_a), .b(d4_b), .s(d4_s),
        .busy(d4_busy), .done(d4_done), .pass(d4_pass), .vec_cnt(d4_vec_cnt),
        .err_cnt(d4_err_cnt), .first_err_valid(d4_fe_valid), .first_err_a(d4_fe_a),
        .first_err_b(d4_fe_b), .first_err_s(d4_fe_s), .first_err_idx(d4_fe_idx)
    );

    function automatic logic [NB-1:0] ref_sum(input logic [NB-1:0] x, input logic [NB-1:0] y);
        return NB'((int'(x) + int'(y)) % (1 << NB));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, busy, done, pass, fe_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {in_ready, busy, done, pass, fe_valid});
        checks++;
        if ({vec_cnt, err_cnt, fe_idx, fe_a, fe_b, fe_s} !== '0)
            $display("FAIL reset_fields: got %h expected 0", {vec_cnt, err_cnt, fe_idx, fe_a, fe_b, fe_s});
        checks++;
        if ({d4_ready, d4_busy, d4_done, d4_pass, d4_fe_valid, d4_vec_cnt, d4_err_cnt} !== '0)
            $display("FAIL reset_dut4: got %h expected 0",
                     {d4_ready, d4_busy, d4_done, d4_pass, d4_fe_valid, d4_vec_cnt, d4_err_cnt});
        if ({in_ready, busy, done, pass, fe_valid} !== 5'b0) errors++;
        if ({vec_cnt, err_cnt, fe_idx, fe_a, fe_b, fe_s} !== '0) errors++;
        if ({d4_ready, d4_busy, d4_done, d4_pass, d4_fe_valid, d4_vec_cnt, d4_err_cnt} !== '0)
            errors++;
        rst = 1'b0;
    endtask

    // Drives one run from tv_* with valid pattern tv_v; a start pulse (num_vec=1) is
    // injected at cycle glitch_cyc to show that start is ignored while running.
    task automatic run_and_check(input int n, input int glitch_cyc);
        int            exp_err = 0;
        int            exp_idx = 0;
        bit            exp_fe = 0;
        int            idx = 0;
        int            cyc = 0;
        bit            take;
        logic [NB-1:0] ea, eb, es;
        for (int i = 0; i < n; i++) begin
            if (tv_s[i] !== ref_sum(tv_a[i], tv_b[i])) begin
                if (!exp_fe) begin
                    exp_fe  = 1;
                    exp_idx = i;
                end
                exp_err++;
            end
        end
        ea = exp_fe ? tv_a[exp_idx] : '0;
        eb = exp_fe ? tv_b[exp_idx] : '0;
        es = exp_fe ? tv_s[exp_idx] : '0;

        start   = 1'b1;
        num_vec = CW'(n);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: got busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        while (idx < n && cyc < 120) begin
            in_valid = tv_v[cyc];
            a = tv_a[idx];
            b = tv_b[idx];
            s = tv_s[idx];
            if (cyc == glitch_cyc) begin
                start   = 1'b1;
                num_vec = CW'(1);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL in_ready_run: cycle %0d got %b expected 1", cyc, in_ready);
            end
            take = in_valid && in_ready;
            @(negedge clk);
            start   = 1'b0;
            num_vec = CW'(n);
            if (take) idx++;
            cyc++;
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL accept_timeout: got %0d accepts expected %0d", idx, n);
        end
        // Drain cycle: an extra valid vector here must not be taken.
        in_valid = 1'b1;
        a = 7'd1;
        b = 7'd1;
        s = 7'd0;
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_state: got ready=%b done=%b busy=%b expected 0 0 1",
                     in_ready, done, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_timing: got done=%b busy=%b ready=%b expected 1 0 0",
                     done, busy, in_ready);
        end
        checks++;
        if (vec_cnt !== CW'(n)) begin
            errors++;
            $display("FAIL vec_cnt: got %0d expected %0d", vec_cnt, n);
        end
        checks++;
        if (err_cnt !== CW'(exp_err)) begin
            errors++;
            $display("FAIL err_cnt: got %0d expected %0d", err_cnt, exp_err);
        end
        checks++;
        if (pass !== (exp_err == 0)) begin
            errors++;
            $display("FAIL pass: got %b expected %b", pass, exp_err == 0);
        end
        checks++;
        if (fe_valid !== exp_fe || fe_idx !== CW'(exp_fe ? exp_idx : 0)) begin
            errors++;
            $display("FAIL first_err_idx: got v=%b idx=%0d expected v=%b idx=%0d",
                     fe_valid, fe_idx, exp_fe, exp_fe ? exp_idx : 0);
        end
        checks++;
        if (fe_a !== ea || fe_b !== eb || fe_s !== es) begin
            errors++;
            $display("FAIL first_err_abs: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                     fe_a, fe_b, fe_s, ea, eb, es);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || vec_cnt !== CW'(n)) begin
            errors++;
            $display("FAIL done_hold: got done=%b vec_cnt=%0d expected 1 %0d", done, vec_cnt, n);
        end
    endtask

    task automatic fill_valid(input bit all_ones);
        for (int i = 0; i < 128; i++) tv_v[i] = all_ones ? 1'b1 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic test_basic();
        int va[6] = '{0, 2, 5, 24, 124, 54};
        int vb[6] = '{0, 3, 10, 13, 15, 43};
        int vs[6] = '{0, 5, 15, 37, 11, 97};
        for (int i = 0; i < 6; i++) begin
            tv_a[i] = NB'(va[i]);
            tv_b[i] = NB'(vb[i]);
            tv_s[i] = NB'(vs[i]);
        end
        fill_valid(1'b1);
        run_and_check(6, -1);
    endtask

    task automatic test_errors();
        for (int i = 0; i < 5; i++) begin
            tv_a[i] = NB'($urandom);
            tv_b[i] = NB'($urandom);
            tv_s[i] = ref_sum(tv_a[i], tv_b[i]);
        end
        tv_s[2] = tv_s[2] ^ 7'h10;
        tv_s[4] = tv_s[4] ^ 7'h01;
        fill_valid(1'b1);
        run_and_check(5, -1);
    endtask

    task automatic test_valid_gaps();
        for (int i = 0; i < 3; i++) begin
            tv_a[i] = NB'($urandom);
            tv_b[i] = NB'($urandom);
            tv_s[i] = ref_sum(tv_a[i], tv_b[i]);
        end
        fill_valid(1'b1);
        tv_v[1] = 1'b0;
        tv_v[2] = 1'b0;
        run_and_check(3, -1);
    endtask

    task automatic test_zero_vec();
        start   = 1'b1;
        num_vec = '0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_vec_state: got done=%b pass=%b busy=%b expected 1 1 0",
                     done, pass, busy);
        end
        checks++;
        if (vec_cnt !== '0 || err_cnt !== '0 || fe_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_vec_cnt: got vec=%0d err=%0d fe=%b expected 0 0 0",
                     vec_cnt, err_cnt, fe_valid);
        end
    endtask

    task automatic test_start_in_run();
        for (int i = 0; i < 4; i++) begin
            tv_a[i] = NB'($urandom);
            tv_b[i] = NB'($urandom);
            tv_s[i] = ref_sum(tv_a[i], tv_b[i]);
        end
        tv_s[0] = tv_s[0] + 7'd1;
        fill_valid(1'b1);
        run_and_check(4, 2);
    endtask

    task automatic test_mid_reset();
        start   = 1'b1;
        num_vec = CW'(5);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        a = 7'd3;
        b = 7'd4;
        s = 7'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy, done, pass, fe_valid} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b expected 00000",
                     {in_ready, busy, done, pass, fe_valid});
        end
        checks++;
        if ({vec_cnt, err_cnt, fe_idx, fe_a, fe_b, fe_s} !== '0) begin
            errors++;
            $display("FAIL mid_reset_fields: got %h expected 0",
                     {vec_cnt, err_cnt, fe_idx, fe_a, fe_b, fe_s});
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tv_a[i] = NB'($urandom);
            tv_b[i] = NB'($urandom);
            tv_s[i] = ref_sum(tv_a[i], tv_b[i]);
        end
        tv_s[1] = ~tv_s[1];
        fill_valid(1'b1);
        run_and_check(4, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                tv_a[i] = NB'($urandom);
                tv_b[i] = NB'($urandom);
                tv_s[i] = ref_sum(tv_a[i], tv_b[i]);
                if ($urandom_range(0, 3) == 0) tv_s[i] = tv_s[i] ^ NB'($urandom_range(1, 127));
            end
            fill_valid(1'b0);
            run_and_check(n, (r % 2 == 0) ? int'($urandom_range(0, 5)) : -1);
        end
    endtask

    // 4-bit instance: (6,10,0) is 16 mod 16 and must pass; (6,10,15) must fail.
    task automatic test_nbit4();
        for (int run = 1; run <= 2; run++) begin
            int idx = 0;
            int cyc = 0;
            d4_start = 1'b1;
            d4_num   = CW'(run);
            @(negedge clk);
            d4_start = 1'b0;
            d4_valid = 1'b1;
            while (idx < run && cyc < 20) begin
                d4_a = 4'd6;
                d4_b = 4'd10;
                d4_s = (idx == 1) ? 4'd15 : 4'd0;
                if (d4_ready) begin
                    @(negedge clk);
                    idx++;
                end else begin
                    @(negedge clk);
                end
                cyc++;
            end
            d4_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (d4_done !== 1'b1 || d4_vec_cnt !== CW'(run) || d4_err_cnt !== CW'(run - 1)) begin
                errors++;
                $display("FAIL nbit4_counts: got done=%b vec=%0d err=%0d expected 1 %0d %0d",
                         d4_done, d4_vec_cnt, d4_err_cnt, run, run - 1);
            end
            checks++;
            if (d4_pass !== (run == 1)) begin
                errors++;
                $display("FAIL nbit4_pass: got %b expected %b", d4_pass, run == 1);
            end
            if (run == 2) begin
                checks++;
                if ({d4_fe_valid, d4_fe_a, d4_fe_b, d4_fe_s} !== {1'b1, 4'd6, 4'd10, 4'd15}
                    || d4_fe_idx !== CW'(1)) begin
                    errors++;
                    $display("FAIL nbit4_first_err: got v=%b (%0d,%0d,%0d) idx=%0d expected 1 (6,10,15) 1",
                             d4_fe_valid, d4_fe_a, d4_fe_b, d4_fe_s, d4_fe_idx);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_zero_vec();
        test_valid_gaps();
        test_start_in_run();
        test_mid_reset();
        test_random();
        test_nbit4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cla_sum_checker.md
Name: cla_sum_checker

Overview:
- Sequential response checker that sits at the output side of the decomposed carry-lookahead adder.
- Consumes a stream of (a, b, s) triples over a valid/ready handshake and compares each s against the golden sum (a+b) mod 2^NBIT.
- Counts vectors and mismatches, and latches the first failing vector.
- Lets self-checking benches and on-chip BIST report pass/fail without a waveform.

Parameters:
- NBIT, 7: adder operand/sum width; must match the adder's constants.
- CNT_W, 16: width of the vector and error counters and of num_vec.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a run of num_vec vectors. Honoured only in IDLE or DONE.
- num_vec  input  CNT_W  number of vectors in the run; sampled when start is accepted.
- in_valid  input  1  a, b and s are valid this cycle.
- in_ready  output  1  checker accepts a vector this cycle.
- a  input  NBIT  adder operand A.
- b  input  NBIT  adder operand B.
- s  input  NBIT  adder sum under test.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE.
- pass  output  1  high in DONE only when err_cnt==0.
- vec_cnt  output  CNT_W  vectors compared so far.
- err_cnt  output  CNT_W  mismatches so far; saturates at all-ones.
- first_err_valid  output  1  a mismatch has been latched.
- first_err_a  output  NBIT  A of the first mismatch.
- first_err_b  output  NBIT  B of the first mismatch.
- first_err_s  output  NBIT  S of the first mismatch.
- first_err_idx  output  CNT_W  0-based index of the first mismatch.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, and every output is 0. This includes in_ready, busy, done, pass, both counters, first_err_valid and the first_err_* fields. Reset mid-run aborts the run and discards the pipeline.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0.
  - start=1 with num_vec>0 -> RUN. Counters, first_err_* and the accept counter are cleared; num_vec is latched.
  - start=1 with num_vec==0 -> DONE with pass=1.
- RUN: in_ready=1.
  - Handshake occurs when in_valid && in_ready. The triple is registered into a one-entry compare stage, and the accept count increments.
  - The cycle in which the accept count reaches the latched num_vec, in_ready drops to 0 on the next cycle and the state moves to DRAIN.
  - start is ignored in RUN.
- Compare stage: 1-cycle latency, from accept edge to counter update edge.
  - Golden sum = (a+b) truncated to NBIT bits; the carry-out is discarded, so overflow wraps.
  - Each compare increments vec_cnt.
  - On a mismatch, err_cnt increments (saturating). If first_err_valid=0, a, b, s and the index are latched and first_err_valid is set.
  - first_err_* never changes again until the next start or rst.
- DRAIN: in_ready=0. Waits one cycle for the final compare to retire, then -> DONE.
- DONE: done=1; pass=(err_cnt==0).
  - All results hold until start, which behaves as in IDLE and clears the results.
- in_valid while in_ready=0 is ignored; no vector is captured.
- Back-to-back vectors are accepted every cycle in RUN, giving full throughput.
- Exactly num_vec vectors are accepted per run. Excess valid cycles are not counted.

Test Plan:
- NBIT=7, start num_vec=6; stream correct triples (0,0,0), (2,3,5), (5,10,15), (24,13,37), (124,15,11 wrapped), (54,43,97) with in_valid held high -> six consecutive accepts; done 2 cycles after the last accept; vec_cnt=6, err_cnt=0, pass=1, first_err_valid=0.
- NBIT=4, vector (6,10,0) -> counts as a pass (16 mod 16 = 0). Vector (6,10,15) -> err_cnt=1 and first_err_{a,b,s}=(6,10,15).
- 5 vectors with wrong s at indices 2 and 4 -> err_cnt=2, first_err_idx=2 (not 4), pass=0.
- in_valid toggling 1,0,0,1,1 with num_vec=3 -> only the valid cycles are accepted; vec_cnt=3 at done. A 4th valid after the 3rd accept is not taken, because in_ready=0.
- start with num_vec=0 -> DONE on the next cycle, pass=1, counters 0. start asserted during RUN -> no effect.
- rst asserted mid-run after 2 accepts -> next cycle state IDLE, all outputs 0. A new start runs cleanly from index 0.
